// File: rtl/dbg_bridge_pkg.sv
// Shared opcodes, response codes and FSM state encoding for the debug command bridge.
package dbg_bridge_pkg;

  localparam logic [7:0] OP_PGM  = 8'h50;
  localparam logic [7:0] OP_CLR  = 8'h52;
  localparam logic [7:0] OP_CMD  = 8'h43;
  localparam logic [7:0] RSP_ACK = 8'h06;
  localparam logic [7:0] RSP_NAK = 8'h15;

  typedef enum logic [3:0] {
    IDLE,
    PGM_AH,
    PGM_AL,
    PGM_LEN,
    PGM_DATA,
    PGM_WR,
    CLR,
    CMD_ARG,
    CMD_ISSUE,
    CMD_WAIT,
    RESP
  } state_e;

endpackage

// File: rtl/dbg_cmd_bridge.sv
// Byte-stream host bridge: code ROM programming/clear and harness command issue.
// Optional CMD_WAIT timeout is enabled with `define DBG_BRIDGE_TIMEOUT_EN.
module dbg_cmd_bridge
  import dbg_bridge_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic [3:0]  debug_cmd,
  input  logic        command_complete,
  output logic        program_rom_mode,
  output logic [11:0] code_rom_addr,
  output logic [7:0]  code_rom_data,
  output logic        reset_code_rom_n,
  output logic        busy
);

  state_e      state_q, state_d;
  logic [11:0] addr_q, addr_d;
  logic [8:0]  cnt_q, cnt_d;
  logic [3:0]  arg_q, arg_d;
  logic        rx_ready_q, rx_ready_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic        tx_valid_q, tx_valid_d;
  logic [3:0]  debug_cmd_q, debug_cmd_d;
  logic        prog_q, prog_d;
  logic [11:0] rom_addr_q, rom_addr_d;
  logic [7:0]  rom_data_q, rom_data_d;
  logic        clr_n_q, clr_n_d;
  logic        busy_q, busy_d;
  logic        rx_fire;

`ifdef DBG_BRIDGE_TIMEOUT_EN
  localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] wait_q, wait_d;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES == 0);
`endif

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    cnt_d      = cnt_q;
    arg_d      = arg_q;
    tx_data_d  = tx_data_q;
    rom_addr_d = rom_addr_q;
    rom_data_d = rom_data_q;
`ifdef DBG_BRIDGE_TIMEOUT_EN
    wait_d     = '0;
`endif
    rx_fire    = rx_ready_q & rx_valid;

    case (state_q)
      IDLE: if (rx_fire) begin
        case (rx_data)
          OP_PGM:  state_d = PGM_AH;
          OP_CLR:  state_d = CLR;
          OP_CMD:  state_d = CMD_ARG;
          default: begin state_d = RESP; tx_data_d = RSP_NAK; end
        endcase
      end
      PGM_AH: if (rx_fire) begin
        addr_d[11:8] = rx_data[3:0];
        state_d      = PGM_AL;
      end
      PGM_AL: if (rx_fire) begin
        addr_d[7:0] = rx_data;
        state_d     = PGM_LEN;
      end
      PGM_LEN: if (rx_fire) begin
        cnt_d   = (rx_data == 8'h00) ? 9'd256 : {1'b0, rx_data};
        state_d = PGM_DATA;
      end
      PGM_DATA: if (rx_fire) begin
        rom_addr_d = addr_q;
        rom_data_d = rx_data;
        state_d    = PGM_WR;
      end
      PGM_WR: begin
        // 12-bit address rolls 0xFFF -> 0x000 naturally.
        addr_d = addr_q + 12'd1;
        cnt_d  = cnt_q - 9'd1;
        if (cnt_q == 9'd1) begin
          state_d   = RESP;
          tx_data_d = RSP_ACK;
        end else begin
          state_d = PGM_DATA;
        end
      end
      CLR: begin
        state_d   = RESP;
        tx_data_d = RSP_ACK;
      end
      CMD_ARG: if (rx_fire) begin
        if (rx_data == 8'h00) begin
          state_d   = RESP;
          tx_data_d = RSP_ACK;
        end else if (rx_data <= 8'h0F) begin
          arg_d   = rx_data[3:0];
          state_d = CMD_ISSUE;
        end else begin
          state_d   = RESP;
          tx_data_d = RSP_NAK;
        end
      end
      CMD_ISSUE: state_d = CMD_WAIT;
      CMD_WAIT: begin
        if (command_complete) begin
          state_d   = RESP;
          tx_data_d = RSP_ACK;
        end
`ifdef DBG_BRIDGE_TIMEOUT_EN
        else if (wait_q == WAIT_LAST) begin
          state_d   = RESP;
          tx_data_d = RSP_NAK;
        end else begin
          wait_d = wait_q + 16'd1;
        end
`endif
      end
      RESP: if (tx_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Outputs are decoded from the next state so they register alongside it.
    rx_ready_d  = (state_d == IDLE) || (state_d == PGM_AH) || (state_d == PGM_AL) ||
                  (state_d == PGM_LEN) || (state_d == PGM_DATA) || (state_d == CMD_ARG);
    tx_valid_d  = (state_d == RESP);
    debug_cmd_d = (state_d == CMD_ISSUE) ? arg_d : 4'd0;
    prog_d      = (state_d == PGM_WR);
    clr_n_d     = (state_d != CLR);
    busy_d      = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      cnt_q       <= '0;
      arg_q       <= '0;
      rx_ready_q  <= 1'b1;
      tx_data_q   <= '0;
      tx_valid_q  <= 1'b0;
      debug_cmd_q <= '0;
      prog_q      <= 1'b0;
      rom_addr_q  <= '0;
      rom_data_q  <= '0;
      clr_n_q     <= 1'b1;
      busy_q      <= 1'b0;
`ifdef DBG_BRIDGE_TIMEOUT_EN
      wait_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      cnt_q       <= cnt_d;
      arg_q       <= arg_d;
      rx_ready_q  <= rx_ready_d;
      tx_data_q   <= tx_data_d;
      tx_valid_q  <= tx_valid_d;
      debug_cmd_q <= debug_cmd_d;
      prog_q      <= prog_d;
      rom_addr_q  <= rom_addr_d;
      rom_data_q  <= rom_data_d;
      clr_n_q     <= clr_n_d;
      busy_q      <= busy_d;
`ifdef DBG_BRIDGE_TIMEOUT_EN
      wait_q      <= wait_d;
`endif
    end
  end

  assign rx_ready         = rx_ready_q;
  assign tx_data          = tx_data_q;
  assign tx_valid         = tx_valid_q;
  assign debug_cmd        = debug_cmd_q;
  assign program_rom_mode = prog_q;
  assign code_rom_addr    = rom_addr_q;
  assign code_rom_data    = rom_data_q;
  assign reset_code_rom_n = clr_n_q;
  assign busy             = busy_q;

endmodule
